pipe_stage_fifo: RTL and testbench

Parametrised elastic pipeline-stage buffer that replaces fixed single-register stage latches such as IF/ID, ID/EX, EX/MEM and MEM/WB. It carries a packed payload of configurable width through a DEPTH-entry circular buffer with a valid/ready handshake on both sides. A flush input discards every held entry. `in_ready_o` is derived from registered state only, which breaks the combinational ready chain that runs from WB back to IF. Each stage wrapper packs its fields (pc, optype info, ld/st info, rd/csr controls, exception flags) into `in_data_i` and unpacks them from `out_data_o`.

---
 rtl/pipe_stage_fifo_pkg.sv | 9 +
 rtl/pipe_stage_fifo.sv | 83 ++++++++
 tb/tb_pipe_stage_fifo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_fifo_pkg.sv
// Shared helpers for the elastic pipeline-stage buffer (pointer sizing).
package pipe_stage_fifo_pkg;

  // Pointers need at least one bit, even for a single-entry buffer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_fifo.sv
// Elastic DEPTH-entry stage buffer, push-to-output latency 1; in_ready_o from registered count only, flush/rst kill output.
// PIPE_STAGE_ZERO_INVALID_EN defined: out_data_o forced to zero whenever out_valid_o is low.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW    = ptr_w(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  // Storage is sized to the pointer range; with DEPTH=1 the second slot is never addressed.
  localparam int MEM_N = 1 << PW;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [MEM_N];
  logic             kill;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reset behaves like a flush so a mid-stream reset also masks the head entry.
  assign kill        = rst || flush_i;
  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0) && !kill;
  assign push        = in_valid_i && in_ready_o && !kill;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

`ifdef PIPE_STAGE_ZERO_INVALID_EN
  assign out_data_o = out_valid_o ? mem_q[rd_ptr_q] : '0;
`else
  assign out_data_o = mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo: DEPTH 4 vector table, DEPTH 2 streaming/random wrap, DEPTH 1 throughput.
module tb_pipe_stage_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       f4, iv4, ir4, or4, ov4;
  logic [7:0] id4, od4;
  logic [2:0] cnt4;
  // DEPTH=2 instance
  logic       f2, iv2, ir2, or2, ov2;
  logic [7:0] id2, od2;
  logic [1:0] cnt2;
  // DEPTH=1 instance
  logic       f1, iv1, ir1, or1, ov1;
  logic [7:0] id1, od1;
  logic [0:0] cnt1;

  pipe_stage_fifo #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .flush_i(f4), .in_valid_i(iv4), .in_ready_o(ir4), .in_data_i(id4),
    .out_valid_o(ov4), .out_ready_i(or4), .out_data_o(od4), .count_o(cnt4));
  pipe_stage_fifo #(.WIDTH(8), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush_i(f2), .in_valid_i(iv2), .in_ready_o(ir2), .in_data_i(id2),
    .out_valid_o(ov2), .out_ready_i(or2), .out_data_o(od2), .count_o(cnt2));
  pipe_stage_fifo #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .flush_i(f1), .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(id1),
    .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .count_o(cnt1));

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
    logic       chk_od;
  } vec_t;

  function automatic vec_t mk(input int fl, iv, id, ordy, e_ir, e_ov, e_od, e_cnt, chk_od);
    vec_t v;
    v.fl = fl[0]; v.iv = iv[0]; v.id = id[7:0]; v.ordy = ordy[0];
    v.e_ir = e_ir[0]; v.e_ov = e_ov[0]; v.e_od = e_od[7:0]; v.e_cnt = e_cnt[2:0];
    v.chk_od = chk_od[0];
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    logic [7:0] q[$];
    logic [7:0] nv, exp1;
    logic       pend, p_push, p_pop;
    int         acc, pops;

    // fl iv id ordy | ir ov od cnt chk_od
    tbl[0]  = mk(0, 1, 'hA0, 0, 1, 0, 'h00, 0, 0);
    tbl[1]  = mk(0, 1, 'hA1, 0, 1, 1, 'hA0, 1, 1);
    tbl[2]  = mk(0, 1, 'hA2, 0, 1, 1, 'hA0, 2, 1);
    tbl[3]  = mk(0, 1, 'hA3, 0, 1, 1, 'hA0, 3, 1);
    tbl[4]  = mk(0, 1, 'hA4, 0, 0, 1, 'hA0, 4, 1);
    tbl[5]  = mk(0, 1, 'hA4, 1, 0, 1, 'hA0, 4, 1);
    tbl[6]  = mk(0, 1, 'hA4, 1, 1, 1, 'hA1, 3, 1);
    tbl[7]  = mk(0, 0, 'h00, 1, 1, 1, 'hA2, 3, 1);
    tbl[8]  = mk(0, 0, 'h00, 1, 1, 1, 'hA3, 2, 1);
    tbl[9]  = mk(0, 0, 'h00, 1, 1, 1, 'hA4, 1, 1);
    tbl[10] = mk(0, 0, 'h00, 0, 1, 0, 'h00, 0, 0);
    tbl[11] = mk(0, 1, 'hB0, 0, 1, 0, 'h00, 0, 0);
    tbl[12] = mk(0, 1, 'hB1, 0, 1, 1, 'hB0, 1, 1);
    tbl[13] = mk(0, 1, 'hB2, 0, 1, 1, 'hB0, 2, 1);
    tbl[14] = mk(1, 1, 'hBB, 1, 1, 0, 'h00, 3, 0);
    tbl[15] = mk(0, 1, 'hCC, 0, 1, 0, 'h00, 0, 0);
    tbl[16] = mk(0, 0, 'h00, 1, 1, 1, 'hCC, 1, 1);
    tbl[17] = mk(0, 0, 'h00, 0, 1, 0, 'h00, 0, 0);

    rst = 1'b1;
    {f4, iv4, or4, f2, iv2, or2, f1, iv1, or1} = '0;
    id4 = '0; id2 = '0; id1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_cnt4", cnt4, 0); chk("rst_ir4", ir4, 1); chk("rst_ov4", ov4, 0);
    chk("rst_cnt2", cnt2, 0); chk("rst_ir2", ir2, 1); chk("rst_ov2", ov2, 0);
    chk("rst_cnt1", cnt1, 0); chk("rst_ir1", ir1, 1); chk("rst_ov1", ov1, 0);
`ifdef PIPE_STAGE_ZERO_INVALID_EN
    chk("rst_od4", od4, 0);
`endif
    @(posedge clk); #1;

    // DEPTH=4: fill, hold-off, drain, flush while holding
    for (int i = 0; i < 18; i++) begin
      f4 = tbl[i].fl; iv4 = tbl[i].iv; id4 = tbl[i].id; or4 = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ir", i), ir4, tbl[i].e_ir);
      chk($sformatf("tbl%0d_ov", i), ov4, tbl[i].e_ov);
      chk($sformatf("tbl%0d_cnt", i), cnt4, tbl[i].e_cnt);
      if (tbl[i].chk_od) chk($sformatf("tbl%0d_od", i), od4, tbl[i].e_od);
`ifdef PIPE_STAGE_ZERO_INVALID_EN
      if (!tbl[i].e_ov) chk($sformatf("tbl%0d_od0", i), od4, 0);
`endif
      @(posedge clk); #1;
    end
    f4 = 0; iv4 = 0; or4 = 0;

    // DEPTH=2 streaming: one transfer per cycle, ready never drops
    for (int i = 0; i < 9; i++) begin
      iv2 = (i < 8); id2 = 8'h11 + 8'(i); or2 = 1'b1;
      @(negedge clk);
      chk($sformatf("strm%0d_ir", i), ir2, 1);
      chk($sformatf("strm%0d_ov", i), ov2, (i != 0));
      if (i != 0) chk($sformatf("strm%0d_od", i), od2, 8'h11 + 8'(i - 1));
      @(posedge clk); #1;
    end
    iv2 = 0; or2 = 0;
    @(posedge clk); #1;

    // DEPTH=2 random push/pop against a queue scoreboard across pointer wrap
    nv = 8'h30; pend = 1'b0;
    for (int i = 0; i < 100; i++) begin
      iv2 = pend || ($urandom_range(0, 2) != 0);
      id2 = nv;
      or2 = $urandom_range(0, 1) != 0;
      @(negedge clk);
      chk($sformatf("rnd%0d_cnt", i), cnt2, q.size());
      chk($sformatf("rnd%0d_ir", i), ir2, (q.size() != 2));
      chk($sformatf("rnd%0d_ov", i), ov2, (q.size() != 0));
      if (q.size() != 0) chk($sformatf("rnd%0d_od", i), od2, q[0]);
      p_push = iv2 && (q.size() != 2);
      p_pop  = or2 && (q.size() != 0);
      pend   = iv2 && !p_push;
      if (p_pop) void'(q.pop_front());
      if (p_push) begin
        q.push_back(nv);
        nv++;
      end
      @(posedge clk); #1;
    end
    iv2 = 0; or2 = 0;

    // DEPTH=1: accepts on alternate cycles, 4 transfers in 8 cycles
    nv = 8'h60; exp1 = 8'h60; acc = 0; pops = 0;
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; id1 = nv; or1 = 1'b1;
      @(negedge clk);
      chk($sformatf("d1_%0d_ir", i), ir1, (i % 2 == 0));
      if (ov1) begin
        chk($sformatf("d1_%0d_od", i), od1, exp1);
        exp1++;
        pops++;
      end
      if (ir1) begin
        acc++;
        nv++;
      end
      @(posedge clk); #1;
    end
    iv1 = 0; or1 = 0;
    chk("d1_accepts", acc, 4);
    chk("d1_pops", pops, 4);

    // Mid-stream reset on DEPTH=2 with data offered: nothing survives
    iv2 = 1'b1; id2 = 8'h5A; or2 = 1'b0;
    @(posedge clk); #1;
    id2 = 8'hEE; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv2 = 1'b0;
    @(negedge clk);
    chk("mrst_cnt2", cnt2, 0);
    chk("mrst_ir2", ir2, 1);
    chk("mrst_ov2", ov2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
